// File: rtl/mic1_regfile_pkg.sv
// Shared constants and types for the Mic-1 register bank:
// C-bus write-enable bit positions, B-bus source codes and the
// memory-channel state encoding.
package mic1_regfile_pkg;

  // C-bus write-enable bit positions within c_sel
  localparam int C_MAR = 0;
  localparam int C_MDR = 1;
  localparam int C_PC  = 2;
  localparam int C_SP  = 3;
  localparam int C_LV  = 4;
  localparam int C_CPP = 5;
  localparam int C_TOS = 6;
  localparam int C_OPC = 7;
  localparam int C_H   = 8;

  // B-bus source codes; every code above B_OPC drives zero
  localparam logic [3:0] B_MDR  = 4'd0;
  localparam logic [3:0] B_PC   = 4'd1;
  localparam logic [3:0] B_MBR  = 4'd2;
  localparam logic [3:0] B_MBRU = 4'd3;
  localparam logic [3:0] B_SP   = 4'd4;
  localparam logic [3:0] B_LV   = 4'd5;
  localparam logic [3:0] B_CPP  = 4'd6;
  localparam logic [3:0] B_TOS  = 4'd7;
  localparam logic [3:0] B_OPC  = 4'd8;

  // Width of the debug stall counter
  localparam int STALL_W = 16;

  // Handshake channel state; the data channel keeps read/write as a separate flag
  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } chan_state_t;

endpackage

// File: rtl/mic1_mem_chan.sv
// One request/response memory handshake channel. A request accepted
// in IDLE raises the strobe from the next cycle until the matching
// response is sampled. Illegal requests and unsolicited responses
// produce a one-cycle err_pulse and are otherwise ignored.
module mic1_mem_chan
  import mic1_regfile_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic req,           // any request this cycle
  input  logic req_conflict,  // simultaneous read and write request
  input  logic dir_in,        // 0 read, 1 write (captured on issue)
  input  logic rsp_rd,        // read response
  input  logic rsp_wr,        // write acknowledge
  output logic strobe,
  output logic pending,
  output logic dir,
  output logic done,          // matching response accepted this cycle
  output logic err_pulse
);

  chan_state_t state, state_next;
  logic        dir_next;
  logic        rsp_match;
  logic        rsp_other;

  // State and direction registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      dir   <= 1'b0;
    end else begin
      state <= state_next;
      dir   <= dir_next;
    end
  end

  // Next state, response acceptance and error detection
  always_comb begin
    state_next = state;
    dir_next   = dir;
    done       = 1'b0;
    err_pulse  = 1'b0;
    rsp_match  = dir ? rsp_wr : rsp_rd;
    rsp_other  = dir ? rsp_rd : rsp_wr;
    case (state)
      IDLE: begin
        if (rsp_rd || rsp_wr) err_pulse = 1'b1;
        if (req) begin
          if (req_conflict) begin
            err_pulse = 1'b1;
          end else begin
            state_next = PEND;
            dir_next   = dir_in;
          end
        end
      end
      PEND: begin
        if (rsp_match) begin
          done       = 1'b1;
          state_next = IDLE;
        end
        if (rsp_other || req) err_pulse = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign strobe  = (state == PEND);
  assign pending = (state == PEND);

endmodule

// File: rtl/mic1_regfile.sv
// Mic-1 register bank: drives the A bus (H) and the encoded B bus,
// loads registers from the C bus, and owns the data (MAR/MDR) and
// fetch (PC->MBR) memory channels. busy stalls the microsequencer.
// Optional debug read port and stall counter: MIC1_REGFILE_DEBUG_EN.
module mic1_regfile
  import mic1_regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int MBR_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [8:0]        c_sel,
  input  logic [3:0]        b_sel,
  input  logic [DATA_W-1:0] c_data,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic              fetch_req,
  output logic [DATA_W-1:0] a_data,
  output logic [DATA_W-1:0] b_data,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  input  logic              mem_wack,
  output logic [DATA_W-1:0] fetch_addr,
  output logic              fetch_rd,
  input  logic [MBR_W-1:0]  fetch_data,
  input  logic              fetch_valid,
  output logic              busy,
`ifdef MIC1_REGFILE_DEBUG_EN
  input  logic [3:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
`endif
  output logic              protocol_err
);

  logic [DATA_W-1:0] mar, mdr, pc, sp, lv, cpp, tos, opc, h;
  logic [MBR_W-1:0]  mbr;
  logic signed [MBR_W-1:0]  mbr_s;
  logic signed [DATA_W-1:0] mbr_sext;
  logic [DATA_W-1:0] mbr_zext;

  logic d_strobe, d_pending, d_dir, d_done, d_err;
  logic f_strobe, f_pending, f_dir, f_done, f_err;

  mic1_mem_chan u_data_chan (
    .clock        (clock),
    .reset        (reset),
    .req          (rd_req | wr_req),
    .req_conflict (rd_req & wr_req),
    .dir_in       (wr_req),
    .rsp_rd       (mem_rvalid),
    .rsp_wr       (mem_wack),
    .strobe       (d_strobe),
    .pending      (d_pending),
    .dir          (d_dir),
    .done         (d_done),
    .err_pulse    (d_err)
  );

  mic1_mem_chan u_fetch_chan (
    .clock        (clock),
    .reset        (reset),
    .req          (fetch_req),
    .req_conflict (1'b0),
    .dir_in       (1'b0),
    .rsp_rd       (fetch_valid),
    .rsp_wr       (1'b0),
    .strobe       (f_strobe),
    .pending      (f_pending),
    .dir          (f_dir),
    .done         (f_done),
    .err_pulse    (f_err)
  );

  // Plain C-bus loads for every register without a memory side
  always_ff @(posedge clock) begin
    if (reset) begin
      mar <= '0; pc <= '0; sp <= '0; lv <= '0; cpp <= '0;
      tos <= '0; opc <= '0; h <= '0;
    end else begin
      if (c_sel[C_MAR]) mar <= c_data;
      if (c_sel[C_PC])  pc  <= c_data;
      if (c_sel[C_SP])  sp  <= c_data;
      if (c_sel[C_LV])  lv  <= c_data;
      if (c_sel[C_CPP]) cpp <= c_data;
      if (c_sel[C_TOS]) tos <= c_data;
      if (c_sel[C_OPC]) opc <= c_data;
      if (c_sel[C_H])   h   <= c_data;
    end
  end

  // MDR: read data beats a C write; C writes frozen while a write is in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      mdr <= '0;
    end else if (d_done && !d_dir) begin
      mdr <= mem_rdata;
    end else if (c_sel[C_MDR] && !(d_pending && d_dir)) begin
      mdr <= c_data;
    end
  end

  // MBR loads only from a completed fetch
  always_ff @(posedge clock) begin
    if (reset) begin
      mbr <= '0;
    end else if (f_done) begin
      mbr <= fetch_data;
    end
  end

  // Sticky protocol error, cleared only by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      protocol_err <= 1'b0;
    end else if (d_err || f_err) begin
      protocol_err <= 1'b1;
    end
  end

  assign mbr_s    = mbr;
  assign mbr_sext = {{(DATA_W-MBR_W){mbr_s[MBR_W-1]}}, mbr_s};
  assign mbr_zext = {{(DATA_W-MBR_W){1'b0}}, mbr};

  // B-bus source select
  always_comb begin
    b_data = '0;
    case (b_sel)
      B_MDR:   b_data = mdr;
      B_PC:    b_data = pc;
      B_MBR:   b_data = mbr_sext;
      B_MBRU:  b_data = mbr_zext;
      B_SP:    b_data = sp;
      B_LV:    b_data = lv;
      B_CPP:   b_data = cpp;
      B_TOS:   b_data = tos;
      B_OPC:   b_data = opc;
      default: b_data = '0;
    endcase
  end

  assign a_data     = h;
  assign mem_addr   = mar;
  assign mem_wdata  = mdr;
  assign mem_rd     = d_strobe & ~d_dir;
  assign mem_wr     = d_strobe & d_dir;
  assign fetch_addr = pc;
  assign fetch_rd   = f_strobe & ~f_dir;
  assign busy       = d_pending | f_pending;

`ifdef MIC1_REGFILE_DEBUG_EN
  logic [STALL_W-1:0] stall_cnt;

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Count cycles spent stalled, holding at full scale
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (busy) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

  // Debug read port over every register plus the stall counter
  always_comb begin
    dbg_data = '0;
    case (dbg_sel)
      4'd0:    dbg_data = mar;
      4'd1:    dbg_data = mdr;
      4'd2:    dbg_data = pc;
      4'd3:    dbg_data = mbr_zext;
      4'd4:    dbg_data = sp;
      4'd5:    dbg_data = lv;
      4'd6:    dbg_data = cpp;
      4'd7:    dbg_data = tos;
      4'd8:    dbg_data = opc;
      4'd9:    dbg_data = h;
      4'd15:   dbg_data = {{(DATA_W-STALL_W){1'b0}}, stall_cnt};
      default: dbg_data = '0;
    endcase
  end
`endif

endmodule

// File: tb/tb_mic1_regfile.sv
// Directed bench for mic1_regfile: register writes, B-bus decode,
// data and fetch handshakes, collisions and protocol errors.
module tb_mic1_regfile;

  logic        clock = 1'b0;
  logic        reset;
  logic [8:0]  c_sel;
  logic [3:0]  b_sel;
  logic [31:0] c_data;
  logic        rd_req, wr_req, fetch_req;
  logic [31:0] a_data, b_data, mem_addr, mem_wdata, mem_rdata, fetch_addr;
  logic        mem_rd, mem_wr, mem_rvalid, mem_wack;
  logic        fetch_rd, fetch_valid, busy, protocol_err;
  logic [7:0]  fetch_data;

  int n_checks = 0;
  int n_fail   = 0;

  mic1_regfile dut (
    .clock        (clock),
    .reset        (reset),
    .c_sel        (c_sel),
    .b_sel        (b_sel),
    .c_data       (c_data),
    .rd_req       (rd_req),
    .wr_req       (wr_req),
    .fetch_req    (fetch_req),
    .a_data       (a_data),
    .b_data       (b_data),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_rdata    (mem_rdata),
    .mem_rvalid   (mem_rvalid),
    .mem_wack     (mem_wack),
    .fetch_addr   (fetch_addr),
    .fetch_rd     (fetch_rd),
    .fetch_data   (fetch_data),
    .fetch_valid  (fetch_valid),
    .busy         (busy),
    .protocol_err (protocol_err)
  );

  always #5 clock = ~clock;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    c_sel = '0; b_sel = '0; c_data = '0;
    rd_req = 0; wr_req = 0; fetch_req = 0;
    mem_rdata = '0; mem_rvalid = 0; mem_wack = 0;
    fetch_data = '0; fetch_valid = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_checks++;
    if (a_data !== 32'h0) begin n_fail++; $display("FAIL reset_a_data got %h want 0", a_data); end
    n_checks++;
    if ({mem_rd, mem_wr, fetch_rd, busy, protocol_err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 00000", {mem_rd, mem_wr, fetch_rd, busy, protocol_err});
    end
    for (int i = 0; i < 9; i++) begin
      b_sel = 4'(i);
      #1;
      n_checks++;
      if (b_data !== 32'h0) begin n_fail++; $display("FAIL reset_b_sel%0d got %h want 0", i, b_data); end
    end
  endtask

  task automatic test_c_write();
    c_sel = 9'h100; c_data = 32'hDEADBEEF;
    tick();
    c_sel = '0;
    n_checks++;
    if (a_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL h_write got %h want deadbeef", a_data); end
    for (int i = 0; i < 9; i++) begin
      b_sel = 4'(i);
      #1;
      n_checks++;
      if (b_data !== 32'h0) begin n_fail++; $display("FAIL h_only_b_sel%0d got %h want 0", i, b_data); end
    end
    // SP and TOS together
    c_sel = 9'h048; c_data = 32'h77;
    tick();
    c_sel = '0;
    b_sel = 4'd4; #1;
    n_checks++;
    if (b_data !== 32'h77) begin n_fail++; $display("FAIL multi_sp got %h want 77", b_data); end
    b_sel = 4'd7; #1;
    n_checks++;
    if (b_data !== 32'h77) begin n_fail++; $display("FAIL multi_tos got %h want 77", b_data); end
    b_sel = 4'd5; #1;
    n_checks++;
    if (b_data !== 32'h0) begin n_fail++; $display("FAIL multi_lv got %h want 0", b_data); end
    b_sel = 4'd12; #1;
    n_checks++;
    if (b_data !== 32'h0) begin n_fail++; $display("FAIL b_sel12 got %h want 0", b_data); end
    n_checks++;
    if (a_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL h_hold got %h want deadbeef", a_data); end
  endtask

  task automatic test_read();
    c_sel = 9'h001; c_data = 32'h40; rd_req = 1;
    tick();
    c_sel = '0; rd_req = 0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (!(busy === 1'b1 && mem_rd === 1'b1 && mem_addr === 32'h40)) begin
        n_fail++; $display("FAIL read_pend%0d got busy=%b rd=%b addr=%h want 1 1 40", i, busy, mem_rd, mem_addr);
      end
      if (i == 2) begin mem_rvalid = 1; mem_rdata = 32'h1234; end
      tick();
    end
    mem_rvalid = 0; mem_rdata = '0;
    b_sel = 4'd0; #1;
    n_checks++;
    if ({busy, mem_rd} !== 2'b00) begin n_fail++; $display("FAIL read_done_ctrl got %b want 00", {busy, mem_rd}); end
    n_checks++;
    if (b_data !== 32'h1234) begin n_fail++; $display("FAIL read_mdr got %h want 1234", b_data); end
    n_checks++;
    if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL read_err got %b want 0", protocol_err); end
  endtask

  task automatic test_fetch();
    c_sel = 9'h004; c_data = 32'h100; fetch_req = 1;
    tick();
    c_sel = '0; fetch_req = 0;
    n_checks++;
    if (!(fetch_rd === 1'b1 && fetch_addr === 32'h100 && busy === 1'b1)) begin
      n_fail++; $display("FAIL fetch_pend got rd=%b addr=%h busy=%b want 1 100 1", fetch_rd, fetch_addr, busy);
    end
    fetch_valid = 1; fetch_data = 8'hF0;
    tick();
    fetch_valid = 0; fetch_data = '0;
    n_checks++;
    if ({fetch_rd, busy} !== 2'b00) begin n_fail++; $display("FAIL fetch_done got %b want 00", {fetch_rd, busy}); end
    b_sel = 4'd2; #1;
    n_checks++;
    if (b_data !== 32'hFFFFFFF0) begin n_fail++; $display("FAIL mbr_sext got %h want fffffff0", b_data); end
    b_sel = 4'd3; #1;
    n_checks++;
    if (b_data !== 32'h000000F0) begin n_fail++; $display("FAIL mbr_zext got %h want 000000f0", b_data); end
    fetch_req = 1;
    tick();
    fetch_req = 0;
    fetch_valid = 1; fetch_data = 8'h7F;
    tick();
    fetch_valid = 0;
    b_sel = 4'd2; #1;
    n_checks++;
    if (b_data !== 32'h0000007F) begin n_fail++; $display("FAIL mbr_sext_pos got %h want 0000007f", b_data); end
  endtask

  task automatic test_mdr_collision();
    rd_req = 1;
    tick();
    rd_req = 0;
    c_sel = 9'h002; c_data = 32'h5; mem_rvalid = 1; mem_rdata = 32'h9;
    tick();
    c_sel = '0; mem_rvalid = 0;
    b_sel = 4'd0; #1;
    n_checks++;
    if (b_data !== 32'h9) begin n_fail++; $display("FAIL mdr_collision got %h want 9", b_data); end
    // Write in flight: MDR frozen against C writes
    wr_req = 1;
    tick();
    wr_req = 0;
    c_sel = 9'h002; c_data = 32'hAA;
    tick();
    c_sel = '0;
    n_checks++;
    if (!(mem_wr === 1'b1 && mem_rd === 1'b0 && mem_wdata === 32'h9)) begin
      n_fail++; $display("FAIL write_pend got wr=%b rd=%b wdata=%h want 1 0 9", mem_wr, mem_rd, mem_wdata);
    end
    mem_wack = 1;
    tick();
    mem_wack = 0;
    n_checks++;
    if ({mem_wr, busy, protocol_err} !== 3'b000 || mem_wdata !== 32'h9) begin
      n_fail++; $display("FAIL write_done got wr/busy/err=%b wdata=%h want 000 9", {mem_wr, busy, protocol_err}, mem_wdata);
    end
  endtask

  task automatic test_protocol_err();
    rd_req = 1; wr_req = 1;
    tick();
    rd_req = 0; wr_req = 0;
    n_checks++;
    if ({mem_rd, mem_wr, busy, protocol_err} !== 4'b0001) begin
      n_fail++; $display("FAIL rd_wr_conflict got %b want 0001", {mem_rd, mem_wr, busy, protocol_err});
    end
    tick(); tick();
    n_checks++;
    if (protocol_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", protocol_err); end
    do_reset();
    n_checks++;
    if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL err_cleared got %b want 0", protocol_err); end
    rd_req = 1;
    tick();
    tick();
    rd_req = 0;
    n_checks++;
    if ({mem_rd, protocol_err} !== 2'b11) begin n_fail++; $display("FAIL rd_while_pend got %b want 11", {mem_rd, protocol_err}); end
    mem_rvalid = 1; mem_rdata = 32'h3;
    tick();
    mem_rvalid = 0;
    n_checks++;
    if ({mem_rd, busy, protocol_err} !== 3'b001) begin
      n_fail++; $display("FAIL no_extra_rd got %b want 001", {mem_rd, busy, protocol_err});
    end
    do_reset();
  endtask

  task automatic test_reset_mid_access();
    rd_req = 1;
    tick();
    rd_req = 0;
    n_checks++;
    if (mem_rd !== 1'b1) begin n_fail++; $display("FAIL mid_pre got %b want 1", mem_rd); end
    do_reset();
    n_checks++;
    if ({mem_rd, busy, protocol_err} !== 3'b000) begin
      n_fail++; $display("FAIL mid_after_reset got %b want 000", {mem_rd, busy, protocol_err});
    end
    mem_rvalid = 1; mem_rdata = 32'h55;
    tick();
    mem_rvalid = 0;
    b_sel = 4'd0; #1;
    n_checks++;
    if (b_data !== 32'h0 || protocol_err !== 1'b1 || mem_rd !== 1'b0) begin
      n_fail++; $display("FAIL late_rvalid got mdr=%h err=%b rd=%b want 0 1 0", b_data, protocol_err, mem_rd);
    end
    do_reset();
    fetch_valid = 1; fetch_data = 8'h12;
    tick();
    fetch_valid = 0;
    b_sel = 4'd3; #1;
    n_checks++;
    if (b_data !== 32'h0 || protocol_err !== 1'b1) begin
      n_fail++; $display("FAIL stray_fetch got mbr=%h err=%b want 0 1", b_data, protocol_err);
    end
  endtask

  initial begin
    test_reset();
    test_c_write();
    test_read();
    test_fetch();
    test_mdr_collision();
    test_protocol_err();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
